// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryption: one cipher round per clock, round keys supplied
// combinationally by an external key expansion block indexed by round.

module aes_byte_sub (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  function automatic logic [7:0] xtime8(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime8(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign dout[8*gi +: 8] = sbox(din[8*gi +: 8]);
    end
  endgenerate

endmodule

module aes_cipher_iter #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         key_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] init_key,
  input  logic [127:0] round_key,
  output logic [3:0]   round,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

  fsm_t         fsm_reg, fsm_next;
  logic [127:0] state_reg, state_next;
  logic [3:0]   round_reg, round_next;
  logic         busy_reg, busy_next;
  logic         done_reg, done_next;
  logic [127:0] ct_reg, ct_next;

  logic [127:0] sb_out, sr_out, mc_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sub
      aes_byte_sub u_sub (
        .din  (state_reg[127-32*gi -: 32]),
        .dout (sb_out[127-32*gi -: 32])
      );
    end

    // Byte b sits at row b%4, column b/4; row r rotates left by r columns.
    for (gi = 0; gi < 16; gi++) begin : g_shift
      localparam int R   = gi % 4;
      localparam int C   = gi / 4;
      localparam int SRC = 4 * ((C + R) % 4) + R;
      assign sr_out[127-8*gi -: 8] = sb_out[127-8*SRC -: 8];
    end

    for (gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr_out[127-32*gi -: 8];
      assign a1 = sr_out[119-32*gi -: 8];
      assign a2 = sr_out[111-32*gi -: 8];
      assign a3 = sr_out[103-32*gi -: 8];
      assign mc_out[127-32*gi -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg   <= IDLE;
      state_reg <= '0;
      round_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ct_reg    <= '0;
    end else begin
      fsm_reg   <= fsm_next;
      state_reg <= state_next;
      round_reg <= round_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      ct_reg    <= ct_next;
    end
  end

  always_comb begin
    fsm_next   = fsm_reg;
    state_next = state_reg;
    round_next = round_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    ct_next    = ct_reg;
    case (fsm_reg)
      IDLE: begin
        if (start && key_ready) begin
          state_next = plaintext ^ init_key;
          round_next = 4'd1;
          busy_next  = 1'b1;
          fsm_next   = ROUND;
        end
      end
      ROUND: begin
        state_next = mc_out ^ round_key;
        round_next = round_reg + 4'd1;
        if (round_reg == 4'(NUM_ROUNDS - 1)) fsm_next = FINAL;
      end
      FINAL: begin
        ct_next    = sr_out ^ round_key;
        done_next  = 1'b1;
        round_next = 4'd0;
        busy_next  = 1'b0;
        fsm_next   = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  assign round      = round_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign ciphertext = ct_reg;

endmodule
